// File: rtl/wr_circ_buf_stream_pkg.sv
// rtl/wr_circ_buf_stream_pkg.sv - shared widths, memory request struct and FSM states for wr_circ_buf_stream
package wr_circ_buf_stream_pkg;

    localparam int FLOWID_W            = 8;
    localparam int MAC_INTERFACE_W     = 256;
    localparam int MAC_BYTES           = MAC_INTERFACE_W / 8;
    localparam int MAC_PADBYTES_W      = $clog2(MAC_BYTES);
    localparam int MSG_DATA_SIZE_WIDTH = 16;
    localparam int MEM_ADDR_W          = 64;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]          addr;
        logic [MSG_DATA_SIZE_WIDTH-1:0] size;
    } mem_req_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ1,
        ST_DATA1,
        ST_REQ2,
        ST_DATA2,
        ST_ACK,
        ST_DONE
    } wr_circ_buf_state_e;

    function automatic logic [MSG_DATA_SIZE_WIDTH-1:0] beats_of(input logic [MSG_DATA_SIZE_WIDTH-1:0] bytes);
        return (bytes >> MAC_PADBYTES_W)
             + {{(MSG_DATA_SIZE_WIDTH-1){1'b0}}, |bytes[MAC_PADBYTES_W-1:0]};
    endfunction

    // Invalid bytes in the final beat of a transfer of the given length.
    function automatic logic [MAC_PADBYTES_W-1:0] pad_of(input logic [MSG_DATA_SIZE_WIDTH-1:0] bytes);
        logic [MSG_DATA_SIZE_WIDTH-1:0] neg;
        neg = -bytes;
        return neg[MAC_PADBYTES_W-1:0];
    endfunction

endpackage

// File: rtl/wr_circ_buf_realign.sv
// rtl/wr_circ_buf_realign.sv - beat counter, held register, wrap realign shift mux, flush and pad generation
module wr_circ_buf_realign
    import wr_circ_buf_stream_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           seg1_i,
    input  logic                           seg2_i,
    input  logic                           split_i,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] beats1_i,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] beats2_i,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] rem_i,
    input  logic [MAC_PADBYTES_W-1:0]      pad1_i,
    input  logic [MAC_PADBYTES_W-1:0]      pad2_i,
    input  logic [MAC_PADBYTES_W-1:0]      sh_i,
    input  logic                           src_val_i,
    input  logic [MAC_INTERFACE_W-1:0]     src_data_i,
    output logic                           src_rdy_o,
    input  logic                           mem_rdy_i,
    output logic                           mem_val_o,
    output logic [MAC_INTERFACE_W-1:0]     mem_data_o,
    output logic                           mem_last_o,
    output logic [MAC_PADBYTES_W-1:0]      mem_pad_o,
    output logic                           seg_done_o,
    output logic                           src_final_o
);

    logic [MSG_DATA_SIZE_WIDTH-1:0] cnt_q, cnt_d;
    logic [MAC_INTERFACE_W-1:0]     held_q, held_d;
    logic [MAC_PADBYTES_W:0]        rsh;
    logic                           active, flush, last_beat, fire;

    always_comb begin
        active    = seg1_i | seg2_i;
        // Once every remaining source beat is consumed, the held tail still owes one beat.
        flush     = seg2_i && (cnt_q >= rem_i);
        last_beat = seg1_i ? (cnt_q == beats1_i - 1'b1) : (cnt_q == beats2_i - 1'b1);
        rsh       = (MAC_PADBYTES_W+1)'(MAC_BYTES) - {1'b0, sh_i};

        src_rdy_o = active & ~flush & mem_rdy_i;
        mem_val_o = flush | (active & src_val_i);
        if (seg2_i && (sh_i != '0)) begin
            mem_data_o = (held_q << {sh_i, 3'b000})
                       | (flush ? '0 : (src_data_i >> {rsh, 3'b000}));
        end else begin
            mem_data_o = src_data_i;
        end
        mem_last_o  = active & last_beat;
        mem_pad_o   = mem_last_o ? (seg1_i ? pad1_i : pad2_i) : '0;
        fire        = mem_val_o & mem_rdy_i;
        seg_done_o  = fire & last_beat;
        src_final_o = seg1_i ? (last_beat & (~split_i | (rem_i == '0)))
                             : (cnt_q == rem_i - 1'b1);

        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
        held_d = held_q;
        if (src_val_i && src_rdy_o) begin
            held_d = src_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            held_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

endmodule

// File: rtl/wr_circ_buf_stream.sv
// rtl/wr_circ_buf_stream.sv - commits a write stream into a per-flow DRAM circular buffer, splitting at the wrap
// Optional feature macro: WR_CIRC_BUF_STATS_EN (completion and split counters).
module wr_circ_buf_stream
    import wr_circ_buf_stream_pkg::*;
#(
    parameter int  BUF_PTR_W = -1,
    localparam int PW        = (BUF_PTR_W < 1) ? 1 : BUF_PTR_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_wr_buf_req_val,
    output logic                           src_wr_buf_req_rdy,
    input  logic [FLOWID_W-1:0]            src_wr_buf_req_flowid,
    input  logic [PW-1:0]                  src_wr_buf_req_offset,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_buf_req_size,
    input  logic                           src_wr_buf_data_val,
    output logic                           src_wr_buf_data_rdy,
    input  logic [MAC_INTERFACE_W-1:0]     src_wr_buf_data,
    input  logic                           src_wr_buf_data_last,
    input  logic [MAC_PADBYTES_W-1:0]      src_wr_buf_data_padbytes,
    output logic                           wr_buf_src_done_val,
    input  logic                           wr_buf_src_done_rdy,
    output logic                           wr_buf_mem_req_val,
    input  logic                           wr_buf_mem_req_rdy,
    output mem_req_struct                  wr_buf_mem_req,
    output logic                           wr_buf_mem_data_val,
    input  logic                           wr_buf_mem_data_rdy,
    output logic [MAC_INTERFACE_W-1:0]     wr_buf_mem_data,
    output logic                           wr_buf_mem_data_last,
    output logic [MAC_PADBYTES_W-1:0]      wr_buf_mem_data_padbytes,
`ifdef WR_CIRC_BUF_STATS_EN
    output logic [31:0]                    stat_req_cnt,
    output logic [31:0]                    stat_split_cnt,
`endif
    input  logic                           mem_wr_buf_resp_val,
    output logic                           mem_wr_buf_resp_rdy
);

    wr_circ_buf_state_e state_q, state_d;

    logic [FLOWID_W-1:0]            flowid_q;
    logic [PW-1:0]                  offset_q;
    logic [MSG_DATA_SIZE_WIDTH-1:0] s1_q, s2_q, beats1_q, beats2_q, rem_q;
    logic [MSG_DATA_SIZE_WIDTH-1:0] s1_w, s2_w;
    logic [31:0]                    room;
    logic [1:0]                     ack_cnt_q, ack_total, ack_need;
    logic                           split_q, req_fire, resp_fire, done_fire;
    logic                           seg1, seg2, seg_done, src_final;

    always_comb begin
        room      = (32'd1 << PW) - 32'(src_wr_buf_req_offset);
        s1_w      = (32'(src_wr_buf_req_size) < room) ? src_wr_buf_req_size : room[MSG_DATA_SIZE_WIDTH-1:0];
        s2_w      = src_wr_buf_req_size - s1_w;
        req_fire  = src_wr_buf_req_val & src_wr_buf_req_rdy;
        resp_fire = mem_wr_buf_resp_val & mem_wr_buf_resp_rdy;
        done_fire = wr_buf_src_done_val & wr_buf_src_done_rdy;
        ack_need  = split_q ? 2'd2 : 2'd1;
        ack_total = ack_cnt_q + {1'b0, resp_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_fire) state_d = (src_wr_buf_req_size == '0) ? ST_DONE : ST_REQ1;
            ST_REQ1:  if (wr_buf_mem_req_rdy) state_d = ST_DATA1;
            ST_DATA1: if (seg_done) state_d = split_q ? ST_REQ2 : ST_ACK;
            ST_REQ2:  if (wr_buf_mem_req_rdy) state_d = ST_DATA2;
            ST_DATA2: if (seg_done) state_d = ST_ACK;
            ST_ACK:   if (ack_total >= ack_need) state_d = ST_DONE;
            ST_DONE:  if (wr_buf_src_done_rdy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_wr_buf_req_rdy   = (state_q == ST_IDLE);
        wr_buf_mem_req_val   = (state_q == ST_REQ1) || (state_q == ST_REQ2);
        wr_buf_mem_req.addr  = MEM_ADDR_W'({flowid_q, (state_q == ST_REQ2) ? {PW{1'b0}} : offset_q});
        wr_buf_mem_req.size  = (state_q == ST_REQ2) ? s2_q : s1_q;
        // Acks may land while later segments are still streaming; accept them throughout.
        mem_wr_buf_resp_rdy  = (state_q == ST_REQ1) || (state_q == ST_DATA1) || (state_q == ST_REQ2)
                            || (state_q == ST_DATA2) || (state_q == ST_ACK);
        wr_buf_src_done_val  = (state_q == ST_DONE);
        seg1                 = (state_q == ST_DATA1);
        seg2                 = (state_q == ST_DATA2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flowid_q  <= '0;
            offset_q  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            beats1_q  <= '0;
            beats2_q  <= '0;
            rem_q     <= '0;
            split_q   <= 1'b0;
            ack_cnt_q <= '0;
        end else if (req_fire) begin
            flowid_q  <= src_wr_buf_req_flowid;
            offset_q  <= src_wr_buf_req_offset;
            s1_q      <= s1_w;
            s2_q      <= s2_w;
            beats1_q  <= beats_of(s1_w);
            beats2_q  <= beats_of(s2_w);
            rem_q     <= beats_of(src_wr_buf_req_size) - beats_of(s1_w);
            split_q   <= (s2_w != '0);
            ack_cnt_q <= '0;
        end else if (resp_fire) begin
            ack_cnt_q <= ack_cnt_q + 2'd1;
        end
    end

    wr_circ_buf_realign u_realign (
        .clk         (clk),
        .rst         (rst),
        .seg1_i      (seg1),
        .seg2_i      (seg2),
        .split_i     (split_q),
        .beats1_i    (beats1_q),
        .beats2_i    (beats2_q),
        .rem_i       (rem_q),
        .pad1_i      (pad_of(s1_q)),
        .pad2_i      (pad_of(s2_q)),
        .sh_i        (s1_q[MAC_PADBYTES_W-1:0]),
        .src_val_i   (src_wr_buf_data_val),
        .src_data_i  (src_wr_buf_data),
        .src_rdy_o   (src_wr_buf_data_rdy),
        .mem_rdy_i   (wr_buf_mem_data_rdy),
        .mem_val_o   (wr_buf_mem_data_val),
        .mem_data_o  (wr_buf_mem_data),
        .mem_last_o  (wr_buf_mem_data_last),
        .mem_pad_o   (wr_buf_mem_data_padbytes),
        .seg_done_o  (seg_done),
        .src_final_o (src_final)
    );

`ifdef WR_CIRC_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt   <= '0;
            stat_split_cnt <= '0;
        end else begin
            if (done_fire) stat_req_cnt <= stat_req_cnt + 32'd1;
            if (req_fire && (s2_w != '0)) stat_split_cnt <= stat_split_cnt + 32'd1;
        end
    end
`else
    logic unused_done_fire;
    assign unused_done_fire = done_fire;
`endif

`ifndef SYNTHESIS
    // The request size drives segmentation; source framing is only cross-checked.
    assert property (@(posedge clk) disable iff (rst)
        (src_wr_buf_data_val && src_wr_buf_data_rdy) |-> (src_wr_buf_data_last == src_final));
    assert property (@(posedge clk) disable iff (rst)
        (src_wr_buf_data_val && src_wr_buf_data_rdy && src_wr_buf_data_last)
            |-> (src_wr_buf_data_padbytes == pad_of(s1_q + s2_q)));
`endif

endmodule

// File: tb/tb_wr_circ_buf_stream.sv
// tb/tb_wr_circ_buf_stream.sv - randomized bench with a byte-image model of the flow circular buffer
module tb_wr_circ_buf_stream;
    import wr_circ_buf_stream_pkg::*;

    localparam int PW  = 12;
    localparam int BUF = 1 << PW;
    localparam int B   = MAC_INTERFACE_W / 8;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           req_val, req_rdy;
    logic [FLOWID_W-1:0]            req_flowid;
    logic [PW-1:0]                  req_offset;
    logic [MSG_DATA_SIZE_WIDTH-1:0] req_size;
    logic                           data_val, data_rdy, data_last;
    logic [MAC_INTERFACE_W-1:0]     data;
    logic [MAC_PADBYTES_W-1:0]      data_pad;
    logic                           done_val, done_rdy;
    logic                           mreq_val, mreq_rdy;
    mem_req_struct                  mreq;
    logic                           mdata_val, mdata_rdy, mdata_last;
    logic [MAC_INTERFACE_W-1:0]     mdata;
    logic [MAC_PADBYTES_W-1:0]      mdata_pad;
    logic                           resp_val, resp_rdy;
`ifdef WR_CIRC_BUF_STATS_EN
    logic [31:0]                    stat_req_cnt, stat_split_cnt;
`endif

    always #5 clk = ~clk;

    wr_circ_buf_stream #(.BUF_PTR_W(PW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .src_wr_buf_req_val       (req_val),
        .src_wr_buf_req_rdy       (req_rdy),
        .src_wr_buf_req_flowid    (req_flowid),
        .src_wr_buf_req_offset    (req_offset),
        .src_wr_buf_req_size      (req_size),
        .src_wr_buf_data_val      (data_val),
        .src_wr_buf_data_rdy      (data_rdy),
        .src_wr_buf_data          (data),
        .src_wr_buf_data_last     (data_last),
        .src_wr_buf_data_padbytes (data_pad),
        .wr_buf_src_done_val      (done_val),
        .wr_buf_src_done_rdy      (done_rdy),
        .wr_buf_mem_req_val       (mreq_val),
        .wr_buf_mem_req_rdy       (mreq_rdy),
        .wr_buf_mem_req           (mreq),
        .wr_buf_mem_data_val      (mdata_val),
        .wr_buf_mem_data_rdy      (mdata_rdy),
        .wr_buf_mem_data          (mdata),
        .wr_buf_mem_data_last     (mdata_last),
        .wr_buf_mem_data_padbytes (mdata_pad),
`ifdef WR_CIRC_BUF_STATS_EN
        .stat_req_cnt             (stat_req_cnt),
        .stat_split_cnt           (stat_split_cnt),
`endif
        .mem_wr_buf_resp_val      (resp_val),
        .mem_wr_buf_resp_rdy      (resp_rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_split = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] pay [0:1023];
    logic [7:0] img [longint];
    int         last_fire_cyc, last_done_cyc, last_segs;

    function automatic logic [MAC_INTERFACE_W-1:0] mk_beat(input int k, input int size);
        logic [MAC_INTERFACE_W-1:0] d;
        int idx;
        d = '0;
        for (int j = 0; j < B; j++) begin
            idx = k * B + j;
            d[MAC_INTERFACE_W-1-8*j -: 8] = (idx < size) ? pay[idx] : 8'hEE;
        end
        return d;
    endfunction

    task automatic idle_inputs();
        req_val   = 1'b0;
        data_val  = 1'b0;
        data_last = 1'b0;
        data_pad  = '0;
        data      = '0;
        mreq_rdy  = 1'b0;
        mdata_rdy = 1'b0;
        resp_val  = 1'b0;
        done_rdy  = 1'b0;
    endtask

    task automatic run_req(input int flow, input int off, input int size, input bit stall,
                           input bit abort_on_seg2, output bit aborted);
        int       nbeats, s1, s2, nexp, beat_idx, segs, seg_beats, seg_bytes, cur_size;
        int       acks_pend, wr_total, nv, errs, fire_cyc, done_cyc;
        longint   exp_addr [2];
        int       exp_size [2];
        longint   cur_addr, a;
        bit       req_sent, done_seen;

        nbeats = (size + B - 1) / B;
        s1     = (size < BUF - off) ? size : BUF - off;
        s2     = size - s1;
        nexp   = 0;
        if (size > 0) begin
            exp_addr[0] = longint'(flow) * BUF + off;
            exp_size[0] = s1;
            nexp = 1;
            if (s2 > 0) begin
                exp_addr[1] = longint'(flow) * BUF;
                exp_size[1] = s2;
                nexp = 2;
            end
        end
        for (int i = 0; i < size; i++) pay[i] = 8'($urandom);
        img.delete();
        req_sent = 0; done_seen = 0; aborted = 0;
        beat_idx = 0; segs = 0; seg_beats = 0; seg_bytes = 0; cur_size = 0; cur_addr = 0;
        acks_pend = 0; wr_total = 0; fire_cyc = -1; done_cyc = -1;

        for (int cyc = 0; cyc < 3000 && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            req_val    = !req_sent;
            req_flowid = FLOWID_W'(flow);
            req_offset = PW'(off);
            req_size   = MSG_DATA_SIZE_WIDTH'(size);
            data_val   = req_sent && (beat_idx < nbeats) && (!stall || ($urandom_range(0, 2) != 0));
            data       = mk_beat(beat_idx, size);
            data_last  = (beat_idx == nbeats - 1);
            data_pad   = data_last ? MAC_PADBYTES_W'((B - size % B) % B) : '0;
            mreq_rdy   = !stall || ($urandom_range(0, 1) != 0);
            mdata_rdy  = !stall || ($urandom_range(0, 3) != 0);
            resp_val   = (acks_pend > 0) && (!stall || ($urandom_range(0, 1) != 0));
            done_rdy   = !stall || ($urandom_range(0, 1) != 0);
            #1;
            if (done_val && done_cyc < 0) done_cyc = cyc;
            if (req_val && req_rdy) begin
                req_sent = 1;
                fire_cyc = cyc;
                if (s2 > 0) n_split++;
            end
            if (data_val && data_rdy) beat_idx++;
            if (mreq_val && mreq_rdy) begin
                if (segs < nexp) begin
                    check("seg_addr", mreq.addr, exp_addr[segs]);
                    check("seg_size", 64'(mreq.size), 64'(exp_size[segs]));
                end else begin
                    check("extra_seg", 64'(segs), 64'(nexp));
                end
                cur_addr = longint'(mreq.addr);
                cur_size = int'(mreq.size);
                seg_beats = 0; seg_bytes = 0;
                segs++;
                if (abort_on_seg2 && segs == 2) aborted = 1;
            end
            if (mdata_val && mdata_rdy) begin
                nv = mdata_last ? B - int'(mdata_pad) : B;
                for (int j = 0; j < nv; j++) begin
                    img[cur_addr + seg_bytes] = mdata[MAC_INTERFACE_W-1-8*j -: 8];
                    seg_bytes++;
                    wr_total++;
                end
                seg_beats++;
                if (mdata_last) begin
                    check("seg_beats", 64'(seg_beats), 64'((cur_size + B - 1) / B));
                    check("seg_pad", 64'(mdata_pad), 64'((B - cur_size % B) % B));
                    acks_pend++;
                end
            end
            if (resp_val && resp_rdy) acks_pend--;
            if (done_val && done_rdy) begin
                done_seen = 1;
                n_done++;
            end
        end

        last_fire_cyc = fire_cyc;
        last_done_cyc = done_cyc;
        last_segs     = segs;
        if (!aborted) begin
            check("done_seen", 64'(done_seen), 64'd1);
            check("nsegs", 64'(segs), 64'(nexp));
            check("wr_bytes", 64'(wr_total), 64'(size));
            errs = 0;
            for (int i = 0; i < size; i++) begin
                a = longint'(flow) * BUF + ((off + i) % BUF);
                if (!img.exists(a)) errs++;
                else if (img[a] !== pay[i]) errs++;
            end
            check("image", 64'(errs), 64'd0);
        end
    endtask

    bit ab;
    int r_flow, r_off, r_size;

    initial begin
        idle_inputs();
        req_flowid = '0; req_offset = '0; req_size = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_rdy", 64'(req_rdy), 64'd1);
        check("rst_mreq_val", 64'(mreq_val), 64'd0);
        check("rst_mdata_val", 64'(mdata_val), 64'd0);
        check("rst_done_val", 64'(done_val), 64'd0);
        check("rst_data_rdy", 64'(data_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req(3, 0, 64, 1'b0, 1'b0, ab);
        run_req(5, 4000, 96, 1'b0, 1'b0, ab);
        run_req(7, 4080, 50, 1'b0, 1'b0, ab);
        run_req(1, 100, 0, 1'b0, 1'b0, ab);
        check("zero_done_lat", 64'(last_done_cyc - last_fire_cyc), 64'd1);
        check("zero_no_mem", 64'(last_segs), 64'd0);
        run_req(2, 4064, 64, 1'b0, 1'b0, ab);
        run_req(4, 4090, 6, 1'b0, 1'b0, ab);
        run_req(6, 4095, 70, 1'b1, 1'b0, ab);
        run_req(7, 4080, 50, 1'b1, 1'b0, ab);

        for (int t = 0; t < 24; t++) begin
            r_flow = $urandom_range(0, 255);
            r_off  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, BUF - 1) : BUF - $urandom_range(1, 100);
            r_size = $urandom_range(1, 300);
            run_req(r_flow, r_off, r_size, 1'b1, 1'b0, ab);
        end

        run_req(9, 4080, 120, 1'b1, 1'b1, ab);
        check("abort_reached", 64'(ab), 64'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        n_split = 0;
        #1;
        check("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        check("mid_rst_mreq_val", 64'(mreq_val), 64'd0);
        check("mid_rst_mdata_val", 64'(mdata_val), 64'd0);
        check("mid_rst_done_val", 64'(done_val), 64'd0);
        run_req(9, 4070, 70, 1'b1, 1'b0, ab);

`ifdef WR_CIRC_BUF_STATS_EN
        @(negedge clk);
        check("stat_req_cnt", 64'(stat_req_cnt), 64'(n_done));
        check("stat_split_cnt", 64'(stat_split_cnt), 64'(n_split));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
